// File: rtl/instr_buffer_if.sv
// Fetch-to-decode instruction buffer bus: fetcher request/response, ROB flush,
// downstream stalls, and the registered decoder output stage.
interface instr_buffer_if #(
    parameter int DEPTH   = 16,
    parameter int INSTR_W = 32,
    parameter int PC_W    = 32
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic               is_hit_from_fetcher;
    logic [INSTR_W-1:0] instr_from_fetcher;
    logic [PC_W-1:0]    pc_from_fetcher;
    logic               is_exception_from_rob;
    logic [PC_W-1:0]    pc_from_rob;
    logic               is_stall_from_rob;
    logic               is_stall_from_rs;
    logic               is_stall_from_slb;
    logic [PC_W-1:0]    pc_to_fetcher;
    logic               fetch_en_to_fetcher;
    logic [INSTR_W-1:0] instr_to_decoder;
    logic [PC_W-1:0]    pc_to_decoder;
    logic               valid_to_decoder;
    logic [CNT_W-1:0]   count_out;

    modport master (
        output is_hit_from_fetcher, instr_from_fetcher, pc_from_fetcher,
        output is_exception_from_rob, pc_from_rob,
        output is_stall_from_rob, is_stall_from_rs, is_stall_from_slb,
        input  pc_to_fetcher, fetch_en_to_fetcher,
        input  instr_to_decoder, pc_to_decoder, valid_to_decoder, count_out
    );

    modport slave (
        input  is_hit_from_fetcher, instr_from_fetcher, pc_from_fetcher,
        input  is_exception_from_rob, pc_from_rob,
        input  is_stall_from_rob, is_stall_from_rs, is_stall_from_slb,
        output pc_to_fetcher, fetch_en_to_fetcher,
        output instr_to_decoder, pc_to_decoder, valid_to_decoder, count_out
    );
endinterface

// File: rtl/instr_buffer.sv
// Circular instruction queue between fetcher and decoder with a registered
// output stage, fetch-PC generation, ROB flush redirect and almost-full throttle.
module instr_buffer #(
    parameter int              DEPTH        = 16,
    parameter int              INSTR_W      = 32,
    parameter int              PC_W         = 32,
    parameter int              PC_STEP      = 4,
    parameter int              AFULL_MARGIN = 2,
    parameter logic [PC_W-1:0] RESET_PC     = '0
) (
    input logic           clk,
    input logic           rst,
    instr_buffer_if.slave bus
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = IDX_W + 1;

    logic [INSTR_W-1:0] instr_mem [DEPTH];
    logic [PC_W-1:0]    pc_mem    [DEPTH];

    logic [IDX_W-1:0] head;
    logic [IDX_W-1:0] tail;
    logic [CNT_W-1:0] count;

    logic dec_ready;
    logic full;
    logic empty;
    logic push;
    logic pop;
    logic drain_clr;

    // Full/empty come from start-of-cycle count, so a push never bypasses
    // into the output stage in the same cycle.
    always_comb begin
        dec_ready = !(bus.is_stall_from_rob || bus.is_stall_from_rs || bus.is_stall_from_slb);
        full      = (count == CNT_W'(DEPTH));
        empty     = (count == '0);
        push      = bus.is_hit_from_fetcher && !full;
        pop       = (!bus.valid_to_decoder || dec_ready) && !empty;
        drain_clr = dec_ready && bus.valid_to_decoder && empty;
    end

    assign bus.fetch_en_to_fetcher = (DEPTH - int'(count)) > AFULL_MARGIN;
    assign bus.count_out           = count;

    // Entry storage: contents only become visible through the output stage.
    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem[tail] <= bus.instr_from_fetcher;
            pc_mem[tail]    <= bus.pc_from_fetcher;
        end
    end

    // Queue pointers, fetch PC and decoder output stage
    always_ff @(posedge clk) begin
        if (rst) begin
            head                 <= '0;
            tail                 <= '0;
            count                <= '0;
            bus.valid_to_decoder <= 1'b0;
            bus.instr_to_decoder <= '0;
            bus.pc_to_decoder    <= '0;
            bus.pc_to_fetcher    <= RESET_PC;
        end else if (bus.is_exception_from_rob) begin
            head                 <= '0;
            tail                 <= '0;
            count                <= '0;
            bus.valid_to_decoder <= 1'b0;
            bus.pc_to_fetcher    <= bus.pc_from_rob;
        end else begin
            if (push) begin
                tail              <= tail + 1'b1;
                bus.pc_to_fetcher <= bus.pc_to_fetcher + PC_W'(PC_STEP);
            end

            if (pop) begin
                bus.instr_to_decoder <= instr_mem[head];
                bus.pc_to_decoder    <= pc_mem[head];
                bus.valid_to_decoder <= 1'b1;
                head                 <= head + 1'b1;
            end else if (drain_clr) begin
                bus.valid_to_decoder <= 1'b0;
            end

            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: tb/tb_instr_buffer.sv
// Directed bench for instr_buffer: queue-based reference model compared every
// cycle, plus hand-computed checkpoints for fill, drain, stream, flush, wrap, reset.
module tb_instr_buffer;
    localparam int DEPTH   = 16;
    localparam int INSTR_W = 32;
    localparam int PC_W    = 32;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    instr_buffer_if #(.DEPTH(DEPTH), .INSTR_W(INSTR_W), .PC_W(PC_W)) bus ();

    instr_buffer #(
        .DEPTH(DEPTH), .INSTR_W(INSTR_W), .PC_W(PC_W),
        .PC_STEP(4), .AFULL_MARGIN(2), .RESET_PC(32'h0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    ent_t        mq[$];
    logic        mv   = 1'b0;
    logic [31:0] mi   = '0;
    logic [31:0] mp   = '0;
    logic [31:0] mfpc = '0;

    int n_cmp  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    function automatic logic [31:0] instr_of(logic [31:0] pc);
        return 32'hA500_0000 ^ (pc * 3);
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference behaviour: plain queue plus one output slot
    task automatic model_step();
        bit   ready, full, empty, ld, clr, pu;
        ent_t e;
        if (rst) begin
            mq.delete();
            mv = 1'b0; mi = '0; mp = '0; mfpc = 32'h0;
        end else if (bus.is_exception_from_rob) begin
            mq.delete();
            mv = 1'b0;
            mfpc = bus.pc_from_rob;
        end else begin
            ready = !(bus.is_stall_from_rob || bus.is_stall_from_rs || bus.is_stall_from_slb);
            full  = (mq.size() == DEPTH);
            empty = (mq.size() == 0);
            ld    = (!mv || ready) && !empty;
            clr   = ready && mv && empty;
            pu    = bus.is_hit_from_fetcher && !full;
            if (ld) begin
                e = mq.pop_front();
                mi = e.instr; mp = e.pc; mv = 1'b1;
            end else if (clr) begin
                mv = 1'b0;
            end
            if (pu) begin
                mq.push_back('{instr: bus.instr_from_fetcher, pc: bus.pc_from_fetcher});
                mfpc = mfpc + 32'd4;
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            chk("count", 32'(bus.count_out), 32'(mq.size()));
            chk("count_max", 32'(bus.count_out <= 5'd16), 32'd1);
            chk("valid", 32'(bus.valid_to_decoder), 32'(mv));
            chk("pc_fetch", bus.pc_to_fetcher, mfpc);
            chk("fetch_en", 32'(bus.fetch_en_to_fetcher), 32'((DEPTH - mq.size()) > 2));
            if (mv) begin
                chk("instr_dec", bus.instr_to_decoder, mi);
                chk("pc_dec", bus.pc_to_decoder, mp);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_hit(bit hit, logic [31:0] pc);
        bus.is_hit_from_fetcher = hit;
        bus.pc_from_fetcher     = pc;
        bus.instr_from_fetcher  = instr_of(pc);
    endtask

    initial begin
        int          consumed;
        int          r;
        logic [31:0] base;

        bus.is_exception_from_rob = 1'b0;
        bus.pc_from_rob           = '0;
        bus.is_stall_from_rob     = 1'b0;
        bus.is_stall_from_rs      = 1'b0;
        bus.is_stall_from_slb     = 1'b0;
        drive_hit(1'b1, 32'h999);

        // Reset, with a hit present that must be ignored
        cyc();
        chk_en = 1'b1;
        cyc();
        chk("rst_count", 32'(bus.count_out), 32'd0);
        chk("rst_valid", 32'(bus.valid_to_decoder), 32'd0);
        chk("rst_pc_fetch", bus.pc_to_fetcher, 32'h0);
        chk("rst_instr_dec", bus.instr_to_decoder, 32'h0);
        chk("rst_pc_dec", bus.pc_to_decoder, 32'h0);
        chk("rst_fetch_en", 32'(bus.fetch_en_to_fetcher), 32'd1);
        rst = 1'b0;

        // Fill under stall: first entry lands in the output stage, 16 more fill the queue
        bus.is_stall_from_rs = 1'b1;
        for (int i = 0; i < 18; i++) begin
            drive_hit(1'b1, 32'(i * 4));
            cyc();
            if (i == 13) chk("fill_fetch_en_13", 32'(bus.fetch_en_to_fetcher), 32'd1);
            if (i == 14) begin
                chk("fill_count_14", 32'(bus.count_out), 32'd14);
                chk("fill_fetch_en_14", 32'(bus.fetch_en_to_fetcher), 32'd0);
            end
        end
        drive_hit(1'b0, 32'h0);
        chk("fill_count", 32'(bus.count_out), 32'd16);
        chk("fill_pc_fetch", bus.pc_to_fetcher, 32'h44);
        chk("fill_valid", 32'(bus.valid_to_decoder), 32'd1);
        chk("fill_pc_dec", bus.pc_to_decoder, 32'h0);

        // Drain in order
        bus.is_stall_from_rs = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            cyc();
            chk("drain_pc_dec", bus.pc_to_decoder, 32'(k * 4));
            chk("drain_valid", 32'(bus.valid_to_decoder), 32'd1);
        end
        chk("drain_count", 32'(bus.count_out), 32'd0);
        cyc();
        chk("drain_valid_end", 32'(bus.valid_to_decoder), 32'd0);

        // Streaming: one entry in flight, decoder sees one instruction per cycle
        for (int k = 0; k < 10; k++) begin
            drive_hit(1'b1, 32'h100 + 32'(k * 4));
            cyc();
            chk("stream_count", 32'(bus.count_out), 32'd1);
            chk("stream_valid", 32'(bus.valid_to_decoder), (k == 0) ? 32'd0 : 32'd1);
            if (k > 0) chk("stream_pc_dec", bus.pc_to_decoder, 32'h100 + 32'((k - 1) * 4));
        end
        drive_hit(1'b0, 32'h0);
        repeat (3) cyc();
        chk("stream_idle_valid", 32'(bus.valid_to_decoder), 32'd0);

        // Flush with 5 queued, output valid and a same-cycle hit
        bus.is_stall_from_rs = 1'b1;
        for (int k = 0; k < 6; k++) begin
            drive_hit(1'b1, 32'h200 + 32'(k * 4));
            cyc();
        end
        chk("preflush_count", 32'(bus.count_out), 32'd5);
        chk("preflush_valid", 32'(bus.valid_to_decoder), 32'd1);
        chk("preflush_pc_dec", bus.pc_to_decoder, 32'h200);
        bus.is_exception_from_rob = 1'b1;
        bus.pc_from_rob = 32'h1000;
        drive_hit(1'b1, 32'h300);
        cyc();
        chk("flush_count", 32'(bus.count_out), 32'd0);
        chk("flush_valid", 32'(bus.valid_to_decoder), 32'd0);
        chk("flush_pc_fetch", bus.pc_to_fetcher, 32'h1000);
        bus.is_exception_from_rob = 1'b0;
        bus.is_stall_from_rs = 1'b0;
        drive_hit(1'b0, 32'h0);
        cyc();

        // Wrap: 40 entries through the queue under a random stall pattern
        base = mfpc;
        consumed = 0;
        for (int c = 0; c < 600 && consumed < 40; c++) begin
            r = int'($urandom_range(0, 5));
            bus.is_stall_from_rob = (r == 1);
            bus.is_stall_from_rs  = (r == 2);
            bus.is_stall_from_slb = (r == 3);
            drive_hit(((mfpc - base) >> 2) < 40, mfpc);
            if (bus.valid_to_decoder && r > 3 || bus.valid_to_decoder && r == 0) begin
                chk("wrap_order", bus.pc_to_decoder, base + 32'(consumed * 4));
                consumed++;
            end
            cyc();
        end
        chk("wrap_consumed", 32'(consumed), 32'd40);
        bus.is_stall_from_rob = 1'b0;
        bus.is_stall_from_rs  = 1'b0;
        bus.is_stall_from_slb = 1'b0;
        drive_hit(1'b0, 32'h0);
        repeat (3) cyc();
        chk("wrap_empty", 32'(bus.count_out), 32'd0);

        // Reset beats a simultaneous flush and hit
        bus.is_stall_from_rs = 1'b1;
        for (int k = 0; k < 8; k++) begin
            drive_hit(1'b1, 32'h500 + 32'(k * 4));
            cyc();
        end
        chk("prerst_count", 32'(bus.count_out), 32'd7);
        rst = 1'b1;
        bus.is_exception_from_rob = 1'b1;
        bus.pc_from_rob = 32'h2000;
        drive_hit(1'b1, 32'h600);
        cyc();
        chk("rst2_count", 32'(bus.count_out), 32'd0);
        chk("rst2_valid", 32'(bus.valid_to_decoder), 32'd0);
        chk("rst2_pc_fetch", bus.pc_to_fetcher, 32'h0);
        rst = 1'b0;
        bus.is_exception_from_rob = 1'b0;
        bus.is_stall_from_rs = 1'b0;
        drive_hit(1'b0, 32'h0);
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
